// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes non-memory results through to mem_wb and runs
// a big-endian req/ack data-bus access for loads and stores, stalling until it completes.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_except,
    output logic        stallreq
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            is_load_s;
    logic            is_store_s;
    logic            misalign_s;
    logic [3:0]      sel_s;
    logic [31:0]     swdata_s;

    // Big-endian extraction: offset 0 is the most significant lane.
    function automatic logic [31:0] load_extract(input logic [3:0] op,
                                                 input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            OP_LW:   r = w;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Opcode decode, alignment check and store lane steering.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        misalign_s = 1'b0;
        sel_s      = 4'b1111;
        swdata_s   = 32'd0;
        case (ex_memop)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load_s  = 1'b1;
                misalign_s = ex_addr[0];
            end
            OP_LW: begin
                is_load_s  = 1'b1;
                misalign_s = (ex_addr[1:0] != 2'd0);
            end
            OP_SB: begin
                is_store_s = 1'b1;
                sel_s      = 4'b1000 >> ex_addr[1:0];
                swdata_s   = {4{ex_sdata[7:0]}};
            end
            OP_SH: begin
                is_store_s = 1'b1;
                misalign_s = ex_addr[0];
                sel_s      = ex_addr[1] ? 4'b0011 : 4'b1100;
                swdata_s   = {2{ex_sdata[15:0]}};
            end
            OP_SW: begin
                is_store_s = 1'b1;
                misalign_s = (ex_addr[1:0] != 2'd0);
                swdata_s   = ex_sdata;
            end
            default: begin
                is_load_s = 1'b0;
            end
        endcase
    end

    // Access sequencer: IDLE issues, BUSY waits with timeout, DONE lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((is_load_s || is_store_s) && !misalign_s) begin
                        if (bus_ack) begin
                            rdata_q <= bus_rdata;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= S_BUSY;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        state_q <= S_DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Output decode; reset forces every output low, stall cycles emit a bubble.
    always_comb begin
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = 32'd0;
        bus_sel    = 4'd0;
        bus_wdata  = 32'd0;
        mem_wd     = 5'd0;
        mem_wreg   = 1'b0;
        mem_wdata  = 32'd0;
        mem_except = 1'b0;
        stallreq   = 1'b0;
        if (rst) begin
            stallreq = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!(is_load_s || is_store_s)) begin
                        mem_wd    = ex_wd;
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end else if (misalign_s) begin
                        mem_wd     = ex_wd;
                        mem_except = 1'b1;
                    end else begin
                        bus_req   = 1'b1;
                        bus_we    = is_store_s;
                        bus_addr  = {ex_addr[31:2], 2'b00};
                        bus_sel   = sel_s;
                        bus_wdata = swdata_s;
                        stallreq  = 1'b1;
                    end
                end
                S_BUSY: begin
                    bus_req   = 1'b1;
                    bus_we    = is_store_s;
                    bus_addr  = {ex_addr[31:2], 2'b00};
                    bus_sel   = sel_s;
                    bus_wdata = swdata_s;
                    stallreq  = 1'b1;
                end
                S_DONE: begin
                    mem_wd = ex_wd;
                    if (err_q) begin
                        mem_except = 1'b1;
                    end else if (is_load_s) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = load_extract(ex_memop, ex_addr[1:0], rdata_q);
                    end else begin
                        mem_wreg = 1'b0;
                    end
                end
                default: begin
                    stallreq = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back results are queued when an
// access is issued and compared when the DONE cycle appears.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_except;
    logic        stallreq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] wdata;
        logic        wreg;
        logic        except;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_except(mem_except), .stallreq(stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_memop = 4'd5; ex_addr = 32'h0000_1234; ex_sdata = 32'hFFFF_FFFF;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; bus_ack = 1'b1;
        bus_rdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if ({bus_req, stallreq, mem_wreg, mem_except, bus_we} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_flags: got req/stall/wreg/exc/we=%b, want 00000",
                         {bus_req, stallreq, mem_wreg, mem_except, bus_we});
            end
            n_vec++;
            if ({mem_wd, mem_wdata, bus_addr, bus_sel, bus_wdata} !== 105'd0) begin
                n_err++;
                $display("FAIL reset_data: wd=%h wdata=%h addr=%h sel=%h bwdata=%h, want all 0",
                         mem_wd, mem_wdata, bus_addr, bus_sel, bus_wdata);
            end
            next_cycle();
        end
        rst = 1'b0; ex_memop = 4'd0; bus_ack = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [3:0] ops[2] = '{4'd0, 4'd12};
        for (int i = 0; i < 2; i++) begin
            ex_memop = ops[i]; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678 + i;
            ex_addr = 32'h0000_0003;
            @(negedge clk);
            n_vec++;
            if (mem_wd !== 5'd5 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678 + i) begin
                n_err++;
                $display("FAIL passthrough_%0d: got wd=%0d wreg=%b wdata=%h, want 5 1 %h",
                         i, mem_wd, mem_wreg, mem_wdata, 32'h1234_5678 + i);
            end
            n_vec++;
            if (stallreq !== 1'b0 || bus_req !== 1'b0 || mem_except !== 1'b0) begin
                n_err++;
                $display("FAIL passthrough_ctl_%0d: got stall=%b req=%b exc=%b, want 0 0 0",
                         i, stallreq, bus_req, mem_except);
            end
            next_cycle();
        end
    endtask

    // waits < 0 means ack is never given
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int waits, input logic exp_we, input logic [3:0] exp_sel,
                              input logic chk_wdata, input logic [31:0] exp_bwdata,
                              input exp_t e, input string name);
        exp_t got;
        int   stalls = 0;
        bit   done = 0;
        exp_q.push_back(e);
        ex_memop = op; ex_addr = addr; ex_sdata = sdata; ex_wd = 5'd9; ex_wreg = 1'b1;
        ex_wdata = 32'h5555_5555; bus_rdata = rdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus_ack = (cyc == waits);
            @(negedge clk);
            if (stallreq === 1'b1) begin
                stalls++;
                n_vec++;
                if (bus_req !== 1'b1 || bus_we !== exp_we || bus_sel !== exp_sel ||
                    bus_addr !== {addr[31:2], 2'b00} || mem_wreg !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_bus: got req=%b we=%b sel=%b addr=%h wreg=%b, want 1 %b %b %h 0",
                             name, bus_req, bus_we, bus_sel, bus_addr, mem_wreg,
                             exp_we, exp_sel, {addr[31:2], 2'b00});
                end
                if (chk_wdata) begin
                    n_vec++;
                    if (bus_wdata !== exp_bwdata) begin
                        n_err++;
                        $display("FAIL %s_bwdata: got %h, want %h", name, bus_wdata, exp_bwdata);
                    end
                end
                next_cycle();
            end else begin
                done = 1;
                got = exp_q.pop_front();
                n_vec++;
                if (mem_wdata !== got.wdata || mem_wreg !== got.wreg ||
                    mem_except !== got.except || bus_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_done: got wdata=%h wreg=%b exc=%b req=%b, want %h %b %b 0",
                             name, mem_wdata, mem_wreg, mem_except, bus_req,
                             got.wdata, got.wreg, got.except);
                end
                n_vec++;
                if (stalls !== got.stalls) begin
                    n_err++;
                    $display("FAIL %s_stalls: got %0d stall cycles, want %0d", name, stalls, got.stalls);
                end
                next_cycle();
            end
        end
        bus_ack = 1'b0;
        ex_memop = 4'd0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no DONE cycle within 40 cycles", name);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_lb_wait();
        run_access(4'd1, 32'h0000_1001, 32'd0, 32'h11F0_2233, 3, 1'b0, 4'hF, 1'b0, 32'd0,
                   '{32'hFFFF_FFF0, 1'b1, 1'b0, 4}, "lb");
        run_access(4'd2, 32'h0000_1001, 32'd0, 32'h11F0_2233, 3, 1'b0, 4'hF, 1'b0, 32'd0,
                   '{32'h0000_00F0, 1'b1, 1'b0, 4}, "lbu");
    endtask

    task automatic test_stores();
        run_access(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 32'd0, 0, 1'b1, 4'b0011, 1'b1, 32'hBEEF_BEEF,
                   '{32'd0, 1'b0, 1'b0, 1}, "sh");
        run_access(4'd6, 32'h0000_2006, 32'h1234_565A, 32'd0, 1, 1'b1, 4'b0010, 1'b1, 32'h5A5A_5A5A,
                   '{32'd0, 1'b0, 1'b0, 2}, "sb");
        run_access(4'd8, 32'h0000_2008, 32'hCAFE_F00D, 32'd0, 0, 1'b1, 4'b1111, 1'b1, 32'hCAFE_F00D,
                   '{32'd0, 1'b0, 1'b0, 1}, "sw");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        exp_t        e;
        int          wt;
        for (int off = 0; off < 4; off++) begin
            w  = $urandom;
            b  = 8'((w >> (24 - 8 * off)) & 32'hFF);
            wt = $urandom_range(0, 2);
            e  = '{{{24{b[7]}}, b}, 1'b1, 1'b0, wt + 1};
            run_access(4'd1, 32'h0000_4000 + off, 32'd0, w, wt, 1'b0, 4'hF, 1'b0, 32'd0, e, "bb_lb");
            e  = '{{24'd0, b}, 1'b1, 1'b0, wt + 1};
            run_access(4'd2, 32'h0000_4000 + off, 32'd0, w, wt, 1'b0, 4'hF, 1'b0, 32'd0, e, "bb_lbu");
            if (off % 2 == 0) begin
                h = 16'((w >> (16 - 8 * off)) & 32'hFFFF);
                e = '{{{16{h[15]}}, h}, 1'b1, 1'b0, wt + 1};
                run_access(4'd3, 32'h0000_4000 + off, 32'd0, w, wt, 1'b0, 4'hF, 1'b0, 32'd0, e, "bb_lh");
                e = '{{16'd0, h}, 1'b1, 1'b0, wt + 1};
                run_access(4'd4, 32'h0000_4000 + off, 32'd0, w, wt, 1'b0, 4'hF, 1'b0, 32'd0, e, "bb_lhu");
            end
        end
        w = $urandom;
        run_access(4'd5, 32'h0000_4010, 32'd0, w, 0, 1'b0, 4'hF, 1'b0, 32'd0,
                   '{w, 1'b1, 1'b0, 1}, "bb_lw");
    endtask

    task automatic test_misaligned();
        ex_memop = 4'd5; ex_addr = 32'h0000_3001; ex_wd = 5'd3; ex_wreg = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus_req !== 1'b0 || mem_except !== 1'b1 || mem_wreg !== 1'b0 || stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_lw: got req=%b exc=%b wreg=%b stall=%b, want 0 1 0 0",
                     bus_req, mem_except, mem_wreg, stallreq);
        end
        next_cycle();
        ex_memop = 4'd3; ex_addr = 32'h0000_3003;
        @(negedge clk);
        n_vec++;
        if (bus_req !== 1'b0 || mem_except !== 1'b1 || stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_lh: got req=%b exc=%b stall=%b, want 0 1 0",
                     bus_req, mem_except, stallreq);
        end
        next_cycle();
        ex_memop = 4'd0; ex_wdata = 32'h0BAD_CAFE;
        @(negedge clk);
        n_vec++;
        if (mem_except !== 1'b0 || mem_wdata !== 32'h0BAD_CAFE || stallreq !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_after: got exc=%b wdata=%h stall=%b, want 0 0badcafe 0",
                     mem_except, mem_wdata, stallreq);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        run_access(4'd5, 32'h0000_5000, 32'd0, 32'hFFFF_FFFF, -1, 1'b0, 4'hF, 1'b0, 32'd0,
                   '{32'd0, 1'b0, 1'b1, 4}, "timeout");
        // a fresh access right after the timeout must not inherit the error
        run_access(4'd5, 32'h0000_5004, 32'd0, 32'h0102_0304, 0, 1'b0, 4'hF, 1'b0, 32'd0,
                   '{32'h0102_0304, 1'b1, 1'b0, 1}, "post_timeout");
    endtask

    task automatic test_reset_mid_access();
        ex_memop = 4'd5; ex_addr = 32'h0000_6000; ex_wd = 5'd4; ex_wreg = 1'b1; bus_ack = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (bus_req !== 1'b1 || stallreq !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_busy: got req=%b stall=%b, want 1 1", bus_req, stallreq);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; ex_memop = 4'd0; ex_wdata = 32'h7777_0000; bus_ack = 1'b1;
        bus_rdata = 32'h9999_9999;
        @(negedge clk);
        n_vec++;
        if (bus_req !== 1'b0 || stallreq !== 1'b0 || mem_except !== 1'b0 ||
            mem_wdata !== 32'h7777_0000 || mem_wreg !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after: got req=%b stall=%b exc=%b wdata=%h wreg=%b, want 0 0 0 77770000 1",
                     bus_req, stallreq, mem_except, mem_wdata, mem_wreg);
        end
        next_cycle();
        bus_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0; ex_memop = 4'd0;
        ex_addr = 32'd0; ex_sdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #1;
        test_reset();
        test_passthrough();
        test_lb_wait();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the ex/mem pipeline register and mem_wb.
- Non-memory instructions pass straight through to the write-back fields.
- Loads and stores run a req/ack handshake on the data bus, with big-endian byte/halfword lane steering. The stage holds the pipeline via stallreq until the access completes, times out, or is rejected as misaligned.

Parameters:
TIMEOUT, 16, bus wait cycles in BUSY before the access is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset
ex_wd  in  5  destination register address from ex/mem
ex_wreg  in  1  destination register write enable from ex/mem
ex_wdata  in  32  ALU result from ex/mem
ex_memop  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; 9-15 treated as NONE
ex_addr  in  32  effective memory address
ex_sdata  in  32  store source register value
bus_req  out  1  access request
bus_we  out  1  1=write
bus_addr  out  32  word address {ex_addr[31:2],2'b00}
bus_sel  out  4  byte lane enables, bit3 = bits[31:24]
bus_wdata  out  32  lane-steered store data
bus_ack  in  1  access complete, sampled on clk rising edge
bus_rdata  in  32  read data, valid when bus_ack=1
mem_wd  out  5  to mem_wb
mem_wreg  out  1  to mem_wb
mem_wdata  out  32  to mem_wb
mem_except  out  1  misaligned access or bus timeout, one-cycle flag
stallreq  out  1  hold upstream stages and insert a bubble into mem_wb

Behaviour:
Reset and encoding
- Reset rst is synchronous, active-high; clock clk.
- While rst=1: state forced to IDLE, counter=0, captured-data register=0.
- All outputs read 0 while rst=1, including combinational ones.
- rst mid-access drops bus_req on the next cycle; a late bus_ack is ignored.
- Endianness is big-endian. Offset 0 maps to lane bits[31:24].
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.

State IDLE
- NONE: mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata; stallreq=0, bus_req=0.
- Misaligned op: no bus access; mem_except=1, mem_wreg=0, stallreq=0; stay in IDLE.
- Aligned memory op: bus_req=1 and stallreq=1, combinational.
  - bus_ack=1 at the edge -> DONE.
  - Otherwise -> BUSY with counter=1.
- SB: sel=1000>>addr[1:0]; wdata = byte replicated x4.
- SH: sel=1100 or 0011 by addr[1]; wdata = halfword replicated x2.
- SW: sel=1111.
- Loads: bus_we=0, sel=1111.

State BUSY
- bus_req/we/addr/sel/wdata held stable; stallreq=1.
- Upstream holds ex_* stable while stallreq=1.
- bus_ack=1 -> capture bus_rdata, go to DONE.
- No ack and counter==TIMEOUT-1 -> set err, go to DONE.
- Otherwise counter+1.

State DONE (exactly one cycle)
- bus_req=0, stallreq=0.
- Load, no err: mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata = extracted data.
  - LB/LBU: lane selected by addr[1:0], sign- or zero-extended.
  - LH/LHU: lane selected by addr[1], sign- or zero-extended.
  - LW: the full captured word.
- Store: mem_wreg=0, mem_wdata=0.
- err set: mem_except=1, mem_wreg=0.
- Next state is IDLE; err and counter are cleared.
- Back-to-back memory ops each take a full IDLE->DONE sequence.

Latency
- Zero-wait load: 2 cycles (request cycle, DONE cycle).
- N-wait load: N+2 cycles.
- Non-memory op: 0 added cycles.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_memop=LW -> bus_req=0, stallreq=0, mem_wreg=0, all outputs 0.
- Pass-through: memop=NONE, ex_wd=5, ex_wreg=1, ex_wdata=0x12345678 -> same values on mem_* the same cycle, stallreq=0.
- LB signed: addr=0x1001, ack after 3 wait cycles, rdata=0x11F02233 -> stallreq high 4 cycles; DONE gives mem_wdata=0xFFFFFFF0. Same access as LBU gives 0x000000F0.
- SH: addr=0x2002, sdata=0xAAAABEEF, zero-wait -> bus_we=1, sel=0011, wdata=0xBEEFBEEF; DONE shows mem_wreg=0.
- Misaligned LW: addr=0x3001 -> bus_req=0, mem_except=1, mem_wreg=0, no stall.
- Timeout and reset mid-access:
  - TIMEOUT=4, LW with ack never asserted -> stallreq high for exactly 4 cycles; DONE has mem_except=1, mem_wreg=0.
  - rst in BUSY -> IDLE next cycle, bus_req=0.
